// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: pdm_clk generator, 2-flop input synchronizer, boxcar decimator and FIFO writer.
// Define PDM_MIC_CAPTURE_OVF_CNT_EN to build the dropped-sample counter; otherwise overflow_count reads 0.
module pdm_mic_capture #(
    parameter int CLK_DIV    = 4,
    parameter int DECIMATION = 64,
    parameter int WIDTH      = 16,
    parameter int OVF_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    output logic                 pdm_clk,
    input  logic                 pdm_data,
    input  logic                 full,
    output logic                 write,
    output logic [WIDTH-1:0]     write_data,
    output logic [OVF_WIDTH-1:0] overflow_count
);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DECIMATION);
    localparam int ONES_W = $clog2(DECIMATION + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DECIMATION - 1);
    localparam logic [WIDTH-1:0] DEC_W    = WIDTH'(DECIMATION);

    generate
        if (WIDTH < $clog2(DECIMATION) + 2) begin : g_width_check
            $error("pdm_mic_capture: WIDTH too small to hold -DECIMATION..+DECIMATION");
        end
        if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_div_check
            $error("pdm_mic_capture: CLK_DIV must be even and >= 2");
        end
        if (DECIMATION < 2) begin : g_dec_check
            $error("pdm_mic_capture: DECIMATION must be >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [1:0]           sync_reg;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [BIT_W-1:0]     bit_reg, bit_next;
    logic [ONES_W-1:0]    ones_reg, ones_next;
    logic [ONES_W-1:0]    ones_total;
    logic                 pdm_clk_reg, pdm_clk_next;
    logic                 write_reg, write_next;
    logic [WIDTH-1:0]     write_data_reg, write_data_next;
    logic [WIDTH-1:0]     sample_value;
    logic                 pdm_bit;
    logic                 complete;

    // pdm_data is asynchronous to clock; only sync_reg[1] is ever looked at.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pdm_data};
        end
    end

    assign pdm_bit = sync_reg[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            div_reg        <= '0;
            bit_reg        <= '0;
            ones_reg       <= '0;
            pdm_clk_reg    <= 1'b0;
            write_reg      <= 1'b0;
            write_data_reg <= '0;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            bit_reg        <= bit_next;
            ones_reg       <= ones_next;
            pdm_clk_reg    <= pdm_clk_next;
            write_reg      <= write_next;
            write_data_reg <= write_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        bit_next     = bit_reg;
        ones_next    = ones_reg;
        pdm_clk_next = 1'b0;
        complete     = 1'b0;
        ones_total   = ones_reg + ONES_W'(pdm_bit);

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                    div_next   = '0;
                    bit_next   = '0;
                    ones_next  = '0;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Leaving RUN throws away the partial sample.
                    state_next = IDLE;
                    div_next   = '0;
                    bit_next   = '0;
                    ones_next  = '0;
                end else begin
                    div_next     = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
                    pdm_clk_next = (div_next >= DIV_HALF);
                    if (div_reg == DIV_LAST) begin
                        if (bit_reg == BIT_LAST) begin
                            complete  = 1'b1;
                            bit_next  = '0;
                            ones_next = '0;
                        end else begin
                            bit_next  = bit_reg + 1'b1;
                            ones_next = ones_total;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // 2*n - DECIMATION; WIDTH is guaranteed wide enough for the signed result.
    assign sample_value = (WIDTH'(ones_total) << 1) - DEC_W;

    always_comb begin
        write_next      = complete && !full;
        write_data_next = write_data_reg;
        if (complete && !full) begin
            write_data_next = sample_value;
        end
    end

    assign pdm_clk    = pdm_clk_reg;
    assign write      = write_reg;
    assign write_data = write_data_reg;

`ifdef PDM_MIC_CAPTURE_OVF_CNT_EN
    logic [OVF_WIDTH-1:0] ovf_reg, ovf_next;

    always_comb begin
        ovf_next = ovf_reg;
        if (complete && full && (ovf_reg != '1)) begin
            ovf_next = ovf_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_reg <= '0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    assign overflow_count = ovf_reg;
`else
    assign overflow_count = '0;
`endif

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Self-checking bench for pdm_mic_capture: directed test-plan scenarios plus a randomized run,
// all compared every cycle against a sample-level reference model (popcount of a bit queue).
`timescale 1ns/1ps
module tb_pdm_mic_capture;
    localparam int CLK_DIV    = 4;
    localparam int DECIMATION = 64;
    localparam int WIDTH      = 16;
    localparam int OVF_WIDTH  = 8;
    localparam int SAMPLE_CYCLES = CLK_DIV * DECIMATION;
`ifdef PDM_MIC_CAPTURE_OVF_CNT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic                 clock    = 1'b0;
    logic                 reset_n  = 1'b0;
    logic                 enable   = 1'b0;
    logic                 pdm_data = 1'b0;
    logic                 full     = 1'b0;
    logic                 pdm_clk;
    logic                 write;
    logic [WIDTH-1:0]     write_data;
    logic [OVF_WIDTH-1:0] overflow_count;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    typedef enum int {M_ONES, M_ZEROS, M_ALT, M_RAND} mode_t;
    mode_t mode = M_ONES;

    pdm_mic_capture #(
        .CLK_DIV   (CLK_DIV),
        .DECIMATION(DECIMATION),
        .WIDTH     (WIDTH),
        .OVF_WIDTH (OVF_WIDTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .pdm_clk       (pdm_clk),
        .pdm_data      (pdm_data),
        .full          (full),
        .write         (write),
        .write_data    (write_data),
        .overflow_count(overflow_count)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Waits for the next write pulse; n counts clock edges starting with the next one.
    task automatic wait_write(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 2000) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            seen = write;
        end
        check_value("write_seen", 32'(seen), 32'd1);
    endtask

    // Microphone model: data changes only on the falling clock edge.
    initial begin : data_drv
        int alt_cnt;
        alt_cnt = 0;
        forever begin
            @(negedge clock);
            case (mode)
                M_ONES:  pdm_data = 1'b1;
                M_ZEROS: pdm_data = 1'b0;
                M_ALT: begin
                    alt_cnt++;
                    if (alt_cnt >= CLK_DIV) begin
                        alt_cnt  = 0;
                        pdm_data = ~pdm_data;
                    end
                end
                default: pdm_data = 1'($urandom & 1);
            endcase
        end
    end

    // Reference model: a bit is taken every CLK_DIV cycles of RUN (the value seen two edges
    // earlier, through the synchronizer); a full queue of DECIMATION bits becomes one sample.
    logic                 exp_write   = 1'b0;
    logic                 exp_pdm_clk = 1'b0;
    logic [WIDTH-1:0]     exp_data    = '0;
    logic [OVF_WIDTH-1:0] exp_ovf     = '0;
    bit                   m_running   = 1'b0;
    int                   m_t         = 0;
    bit                   m_bits[$];
    logic                 m_d1 = 1'b0;
    logic                 m_d2 = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_write   = 1'b0;
            exp_pdm_clk = 1'b0;
            exp_data    = '0;
            exp_ovf     = '0;
            m_running   = 1'b0;
            m_t         = 0;
            m_d1        = 1'b0;
            m_d2        = 1'b0;
            m_bits.delete();
        end else begin
            logic bitv;
            int   n;
            bitv      = m_d2;
            m_d2      = m_d1;
            m_d1      = pdm_data;
            exp_write = 1'b0;
            if (!m_running) begin
                if (enable) begin
                    m_running = 1'b1;
                    m_t       = 0;
                    m_bits.delete();
                end
            end else if (!enable) begin
                m_running = 1'b0;
                m_bits.delete();
            end else begin
                m_t++;
                if (m_t % CLK_DIV == 0) begin
                    m_bits.push_back(bitv);
                    if (m_bits.size() == DECIMATION) begin
                        n = 0;
                        foreach (m_bits[i]) n += int'(m_bits[i]);
                        if (!full) begin
                            exp_write = 1'b1;
                            exp_data  = WIDTH'(2 * n - DECIMATION);
                        end else if (OVF_ON && (exp_ovf != '1)) begin
                            exp_ovf = exp_ovf + 1'b1;
                        end
                        m_bits.delete();
                    end
                end
            end
            exp_pdm_clk = m_running && ((m_t % CLK_DIV) >= (CLK_DIV / 2));
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            check_value("model_write", 32'(write), 32'(exp_write));
            check_value("model_write_data", 32'(write_data), 32'(exp_data));
            check_value("model_pdm_clk", 32'(pdm_clk), 32'(exp_pdm_clk));
            check_value("model_overflow", 32'(overflow_count), 32'(exp_ovf));
            if (write) begin
                $display("txn write data=0x%h ovf=%0d t=%0t", write_data, overflow_count, $time);
            end
        end
    end

    initial begin : main
        int         n;
        int         wr_cnt;
        logic [7:0] pat;

        repeat (3) @(negedge clock);
        check_value("rst_write", 32'(write), 32'd0);
        check_value("rst_write_data", 32'(write_data), 32'd0);
        check_value("rst_pdm_clk", 32'(pdm_clk), 32'd0);
        check_value("rst_overflow", 32'(overflow_count), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (5) @(negedge clock);
        check_value("idle_pdm_clk", 32'(pdm_clk), 32'd0);

        // All ones: +DECIMATION, first write SAMPLE_CYCLES edges after RUN entry, then periodic.
        mode   = M_ONES;
        enable = 1'b1;
        wait_write(n);
        check_value("ones_latency", 32'(n - 1), 32'(SAMPLE_CYCLES));
        check_value("ones_data", 32'(write_data), 32'h0040);
        wait_write(n);
        check_value("ones_period", 32'(n), 32'(SAMPLE_CYCLES));
        check_value("ones_data2", 32'(write_data), 32'h0040);

        // All zeros, plus the pdm_clk waveform right after RUN entry.
        enable = 1'b0;
        repeat (4) @(negedge clock);
        mode   = M_ZEROS;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            pat[i] = pdm_clk;
        end
        check_value("pdm_clk_pattern", 32'(pat), 32'hCC);
        wait_write(n);
        check_value("zeros_data", 32'(write_data), 32'hFFC0);

        // Alternating bits.
        enable = 1'b0;
        repeat (4) @(negedge clock);
        mode   = M_ALT;
        enable = 1'b1;
        wait_write(n);
        check_value("alt_latency", 32'(n - 1), 32'(SAMPLE_CYCLES));
        check_value("alt_data", 32'(write_data), 32'h0000);

        // FIFO full across three completions.
        mode = M_ONES;
        wait_write(n);
        full   = 1'b1;
        wr_cnt = 0;
        repeat (900) begin
            @(negedge clock);
            if (write) wr_cnt++;
        end
        check_value("full_no_write", 32'(wr_cnt), 32'd0);
        check_value("full_overflow", 32'(overflow_count), OVF_ON ? 32'd3 : 32'd0);
        full = 1'b0;
        wait_write(n);
        check_value("full_release_wait", 32'(n), 32'(4 * SAMPLE_CYCLES - 900));
        check_value("full_release_data", 32'(write_data), 32'h0040);

        // Enable dropped partway through a sample.
        enable = 1'b0;
        repeat (4) @(negedge clock);
        enable = 1'b1;
        repeat (100) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        check_value("drop_pdm_clk", 32'(pdm_clk), 32'd0);
        wr_cnt = 0;
        repeat (400) begin
            @(negedge clock);
            if (write) wr_cnt++;
        end
        check_value("drop_no_write", 32'(wr_cnt), 32'd0);
        enable = 1'b1;
        wait_write(n);
        check_value("reenable_latency", 32'(n - 1), 32'(SAMPLE_CYCLES));
        check_value("reenable_data", 32'(write_data), 32'h0040);

        // Asynchronous reset mid-sample.
        repeat (150) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_value("async_rst_write", 32'(write), 32'd0);
        check_value("async_rst_write_data", 32'(write_data), 32'd0);
        check_value("async_rst_pdm_clk", 32'(pdm_clk), 32'd0);
        check_value("async_rst_overflow", 32'(overflow_count), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        wait_write(n);
        check_value("post_rst_latency", 32'(n - 1), 32'(SAMPLE_CYCLES));
        check_value("post_rst_data", 32'(write_data), 32'h0040);

        // Randomized stream, FIFO back-pressure and occasional enable toggles.
        mode = M_RAND;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clock);
            full = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) enable = ~enable;
        end
        enable = 1'b0;
        full   = 1'b0;
        repeat (10) @(negedge clock);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
